// File: rtl/cond_defs.sv
// Shared condition-code and flag-index definitions for the execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_defs;

  // Flag bit positions, matching the ALU flags output order in alu_defs.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Instruction condition field encodings.
  typedef enum logic [3:0] {
    COND_EQ  = 4'b0000,
    COND_NE  = 4'b0001,
    COND_CS  = 4'b0010,
    COND_CC  = 4'b0011,
    COND_MI  = 4'b0100,
    COND_PL  = 4'b0101,
    COND_VS  = 4'b0110,
    COND_VC  = 4'b0111,
    COND_HI  = 4'b1000,
    COND_LS  = 4'b1001,
    COND_GE  = 4'b1010,
    COND_LT  = 4'b1011,
    COND_GT  = 4'b1100,
    COND_LE  = 4'b1101,
    COND_AL  = 4'b1110,
    COND_UNC = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Decodes an instruction condition field against a set of N/Z/C/V flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module cond_check
  import cond_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Select the pass term for the requested condition code.
  always_comb begin
    pass = 1'b1;
    case (cond_e'(cond))
      COND_EQ:  pass = z;
      COND_NE:  pass = ~z;
      COND_CS:  pass = c;
      COND_CC:  pass = ~c;
      COND_MI:  pass = n;
      COND_PL:  pass = ~n;
      COND_VS:  pass = v;
      COND_VC:  pass = ~v;
      COND_HI:  pass = c & ~z;
      COND_LS:  pass = ~c | z;
      COND_GE:  pass = (n == v);
      COND_LT:  pass = (n != v);
      COND_GT:  pass = ~z & (n == v);
      COND_LE:  pass = z | (n != v);
      COND_AL:  pass = 1'b1;
      COND_UNC: pass = 1'b1;
      default:  pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional execution: holds the flag register, gates PC/reg/mem writes.
// Latency: write gating is combinational; flags and cond_ex_q_o update on the next edge.
// Backpressure: none; a failed condition or valid_i=0 suppresses all side effects.
module cond_logic
  import cond_defs::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pcs_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       no_write_i,
  output logic [3:0] flags_o,
  output logic       cond_ex_o,
  output logic       cond_ex_q_o,
  output logic       pc_src_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q;
  logic       pass;

  // Conditions are always tested against the registered flags, so a
  // set-and-test in the same cycle sees the old values.
  cond_check u_cond_check (
    .cond  (cond_i),
    .flags (flags_q),
    .pass  (pass)
  );

  // rst_ni in the gate keeps every side effect quiet while reset is held.
  assign cond_ex_o   = rst_ni & valid_i & pass;
  assign pc_src_o    = pcs_i & cond_ex_o;
  assign reg_write_o = reg_w_i & ~no_write_i & cond_ex_o;
  assign mem_write_o = mem_w_i & cond_ex_o;

  // Each flag half loads independently from the ALU when its write is enabled.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_o && flag_w_i[1]) begin
      flags_d[FLAG_N] = alu_flags_i[FLAG_N];
      flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
    end
    if (cond_ex_o && flag_w_i[0]) begin
      flags_d[FLAG_C] = alu_flags_i[FLAG_C];
      flags_d[FLAG_V] = alu_flags_i[FLAG_V];
    end
  end

  // Flag register and registered condition result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q     <= FLAGS_RST;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_o;
    end
  end

  assign flags_o     = flags_q;
  assign cond_ex_q_o = cond_ex_r_q;

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have parameter FLAGS_RST, default 4'b0000, giving the reset value of the flag register.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  instruction in the execute stage is valid.
- cond_i  in  4  instruction condition field.
- alu_flags_i  in  4  flags from the ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- flag_w_i  in  2  flag write request: [1] writes N,Z; [0] writes C,V.
- pcs_i  in  1  instruction writes the PC.
- reg_w_i  in  1  instruction writes the register file.
- mem_w_i  in  1  instruction writes memory.
- no_write_i  in  1  compare-type instruction; suppresses the register write.
- flags_o  out  4  registered flags, same bit order as alu_flags_i.
- cond_ex_o  out  1  condition passes for the current instruction (combinational).
- cond_ex_q_o  out  1  registered cond_ex_o, for multicycle control.
- pc_src_o  out  1  gated PC write.
- reg_write_o  out  1  gated register write.
- mem_write_o  out  1  gated memory write.

Function
REQ-004 The block SHALL evaluate cond_i against flags_o, the current registered flags, and never against alu_flags_i.
REQ-005 The block SHALL decode conditions as follows:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C&~Z
- 1001 LS: ~C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: ~Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 1 (unconditional)
REQ-006 cond_ex_o SHALL equal valid_i & condition-pass.
REQ-007 pc_src_o SHALL equal pcs_i & cond_ex_o.
REQ-008 reg_write_o SHALL equal reg_w_i & ~no_write_i & cond_ex_o.
REQ-009 mem_write_o SHALL equal mem_w_i & cond_ex_o.
REQ-010 The write outputs SHALL have zero latency (combinational from the inputs and the flag register).
REQ-011 On a rising edge with cond_ex_o=1 and flag_w_i[1]=1, flags_o[3:2] SHALL load alu_flags_i[3:2].
REQ-012 On a rising edge with cond_ex_o=1 and flag_w_i[0]=1, flags_o[1:0] SHALL load alu_flags_i[1:0].
REQ-013 The two flag halves SHALL update independently; each half not selected SHALL hold its value.
REQ-014 A failed condition or valid_i=0 SHALL block every flag update and force every write output to 0.
REQ-015 When a flag-setting instruction is followed by a dependent one, the dependent instruction SHALL see the new flags only from the following cycle; same-cycle set-and-test SHALL use the old flags.
REQ-016 cond_ex_q_o SHALL load cond_ex_o on every rising edge.
REQ-017 no_write_i SHALL NOT affect flag updates, pc_src_o or mem_write_o.

Reset
REQ-018 While rst_ni=0, flags_o SHALL be FLAGS_RST and cond_ex_q_o SHALL be 0, asynchronously and independent of clk_i.
REQ-019 While rst_ni=0, pc_src_o, reg_write_o, mem_write_o and cond_ex_o SHALL be forced to 0.
REQ-020 A reset asserted mid-instruction SHALL discard any pending flag update.
REQ-021 After release, the first rising edge with rst_ni=1 SHALL be the first edge that can update state.

Structure
REQ-022 The condition-code enumeration (EQ..AL, UNC) and the flag bit indices (N=3, Z=2, C=1, V=0) SHALL live in shared package cond_defs, alongside alu_defs and with the same flag order as the ALU flags output.
REQ-023 Condition decoding SHALL be a purely combinational sub-module cond_check (inputs cond, flags; output pass).
REQ-024 cond_logic SHALL hold the flag register, cond_ex_q_o and the write gating.

Verification
REQ-025 Reset: rst_ni=0 with all inputs 1 -> flags_o=0000, all write outputs 0; release, then cond_i=1110, reg_w_i=1 -> reg_write_o=1.
REQ-026 Set then test: valid_i=1, cond_i=1110, flag_w_i=11, alu_flags_i=0100 -> next cycle flags_o=0100; then cond_i=0000 -> cond_ex_o=1; cond_i=0001 -> cond_ex_o=0.
REQ-027 Partial write: flags_o=1111, flag_w_i=01, alu_flags_i=0000 -> flags_o=1100.
REQ-028 Blocked update: flags_o=0000, cond_i=0000 (fails), flag_w_i=11, alu_flags_i=1111, mem_w_i=1 -> flags unchanged, mem_write_o=0.
REQ-029 Signed compares: for flags N=1,V=0 -> GE=0, LT=1, LE=1; for Z=0,N=V=1 -> GT=1; check all 16 codes against a model over all 16 flag values.
REQ-030 Compare and async reset:
- no_write_i=1, reg_w_i=1, flag_w_i=11, AL -> reg_write_o=0, flags update.
- rst_ni pulsed low between edges -> flags_o=0000 immediately.
